// File: rtl/register_tree_pq.sv
// register_tree_pq: register binary-heap priority queue with per-node
// valid bits, min/max mode, ready handshake and drop reporting.
module register_tree_pq #(
    parameter int QUEUE_SIZE  = 7,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 8,
    parameter bit MAX_FIRST   = 1'b1,
    localparam int TREE_DEPTH = $clog2(QUEUE_SIZE + 1),
    localparam int NODES      = 2**TREE_DEPTH - 1,
    localparam int CW         = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                   i_CLK,
    input  logic                   i_RSTn,
    input  logic                   i_wrt,
    input  logic                   i_read,
    input  logic [KEY_WIDTH-1:0]   i_key,
    input  logic [VALUE_WIDTH-1:0] i_value,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [KEY_WIDTH-1:0]   o_key,
    output logic [VALUE_WIDTH-1:0] o_value,
    output logic [CW-1:0]          o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_drop
);

    localparam int SW = $clog2(TREE_DEPTH + 1);
    localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          sttl_q, sttl_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic [NODES-1:0]       vld_q, vld_d, vld_s;
    logic [KEY_WIDTH-1:0]   key_q [NODES];
    logic [KEY_WIDTH-1:0]   key_d [NODES];
    logic [KEY_WIDTH-1:0]   key_s [NODES];
    logic [VALUE_WIDTH-1:0] val_q [NODES];
    logic [VALUE_WIDTH-1:0] val_d [NODES];
    logic [VALUE_WIDTH-1:0] val_s [NODES];

    logic is_enq, is_deq, is_rep, is_empty, is_full, acc, ill;

    // a strictly better than b; an invalid node loses to any valid one
    function automatic logic better(
        input logic                 va,
        input logic [KEY_WIDTH-1:0] ka,
        input logic                 vb,
        input logic [KEY_WIDTH-1:0] kb
    );
        if (!va) return 1'b0;
        if (!vb) return 1'b1;
        return MAX_FIRST ? (ka > kb) : (ka < kb);
    endfunction

    assign is_enq   = i_wrt & ~i_read;
    assign is_deq   = i_read & ~i_wrt;
    assign is_rep   = i_wrt & i_read;
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(QUEUE_SIZE));
    assign acc      = (is_enq & ~is_full) | (is_deq & ~is_empty) | is_rep;
    assign ill      = (i_wrt | i_read) & ~acc;

    // one swap pass: even parent levels top-down, then odd ones
    always_comb begin
        logic [NW-1:0]          p, l, r, c;
        logic                   tv;
        logic [KEY_WIDTH-1:0]   tk;
        logic [VALUE_WIDTH-1:0] tw;
        vld_s = vld_q;
        key_s = key_q;
        val_s = val_q;
        p  = '0;
        l  = '0;
        r  = '0;
        c  = '0;
        tv = 1'b0;
        tk = '0;
        tw = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int lv = 0; lv < TREE_DEPTH - 1; lv++) begin
                for (int i = 0; i < NODES / 2; i++) begin
                    if ((lv % 2) == ph && i >= (1 << lv) - 1
                        && i < (2 << lv) - 1) begin
                        p = NW'(i);
                        l = NW'(2 * i + 1);
                        r = NW'(2 * i + 2);
                        c = better(vld_s[r], key_s[r], vld_s[l], key_s[l])
                            ? r : l;
                        if (better(vld_s[c], key_s[c], vld_s[p], key_s[p])) begin
                            tv       = vld_s[p];
                            tk       = key_s[p];
                            tw       = val_s[p];
                            vld_s[p] = vld_s[c];
                            key_s[p] = key_s[c];
                            val_s[p] = val_s[c];
                            vld_s[c] = tv;
                            key_s[c] = tk;
                            val_s[c] = tw;
                        end
                    end
                end
            end
        end
    end

    // next state: apply an accepted op, otherwise take the swap pass
    always_comb begin
        logic [NW-1:0] slot;
        logic          found;
        state_d = state_q;
        sttl_d  = sttl_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        vld_d   = vld_s;
        key_d   = key_s;
        val_d   = val_s;
        slot    = '0;
        found   = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            if (!found && !vld_q[i]) begin
                slot  = NW'(i);
                found = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    vld_d   = vld_q;
                    key_d   = key_q;
                    val_d   = val_q;
                    state_d = SETTLE;
                    sttl_d  = SW'(TREE_DEPTH);
                    if (is_rep) begin
                        vld_d[0] = 1'b1;
                        key_d[0] = i_key;
                        val_d[0] = i_value;
                        if (is_empty) cnt_d = cnt_q + CW'(1);
                    end else if (is_enq) begin
                        vld_d[slot] = 1'b1;
                        key_d[slot] = i_key;
                        val_d[slot] = i_value;
                        cnt_d       = cnt_q + CW'(1);
                    end else begin
                        vld_d[0] = 1'b0;
                        key_d[0] = '0;
                        val_d[0] = '0;
                        cnt_d    = cnt_q - CW'(1);
                    end
                end else if (ill) begin
                    drop_d = 1'b1;
                end
            end
            SETTLE: begin
                sttl_d = sttl_q - SW'(1);
                if (sttl_q == SW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and node storage registers
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            sttl_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < NODES; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sttl_q  <= sttl_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            vld_q   <= vld_d;
            key_q   <= key_d;
            val_q   <= val_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == IDLE) && vld_q[0];
    assign o_key   = vld_q[0] ? key_q[0] : '0;
    assign o_value = vld_q[0] ? val_q[0] : '0;
    assign o_count = cnt_q;
    assign o_empty = is_empty;
    assign o_full  = is_full;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_register_tree_pq.sv
// tb_register_tree_pq: scripted and randomized checks of the max-heap
// and min-heap variants against a multiset reference model.
module tb_register_tree_pq;

    localparam int QS = 7;
    localparam int KW = 8;
    localparam int VW = 4;
    localparam int TD = 3;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          wrt = 1'b0;
    logic          rd = 1'b0;
    logic [KW-1:0] key = '0;
    logic [VW-1:0] val = '0;

    logic          a_rdy, a_vld, a_emp, a_full, a_drop;
    logic [KW-1:0] a_key;
    logic [VW-1:0] a_val;
    logic [CW-1:0] a_cnt;
    logic          b_rdy, b_vld, b_emp, b_full, b_drop;
    logic [KW-1:0] b_key;
    logic [VW-1:0] b_val;
    logic [CW-1:0] b_cnt;

    logic          rdy, ovld, oemp, ofull, odrop;
    logic [KW-1:0] okey;
    logic [VW-1:0] oval;
    logic [CW-1:0] ocnt;

    int tests = 0;
    int fails = 0;
    int mk[$];
    int mv[$];

    register_tree_pq #(
        .QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .MAX_FIRST(1'b1)
    ) u_max (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_wrt(wrt & ~sel), .i_read(rd & ~sel),
        .i_key(key), .i_value(val),
        .o_ready(a_rdy), .o_valid(a_vld), .o_key(a_key), .o_value(a_val),
        .o_count(a_cnt), .o_empty(a_emp), .o_full(a_full), .o_drop(a_drop)
    );

    register_tree_pq #(
        .QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .MAX_FIRST(1'b0)
    ) u_min (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_wrt(wrt & sel), .i_read(rd & sel),
        .i_key(key), .i_value(val),
        .o_ready(b_rdy), .o_valid(b_vld), .o_key(b_key), .o_value(b_val),
        .o_count(b_cnt), .o_empty(b_emp), .o_full(b_full), .o_drop(b_drop)
    );

    always_comb begin
        rdy   = sel ? b_rdy  : a_rdy;
        ovld  = sel ? b_vld  : a_vld;
        oemp  = sel ? b_emp  : a_emp;
        ofull = sel ? b_full : a_full;
        odrop = sel ? b_drop : a_drop;
        okey  = sel ? b_key  : a_key;
        oval  = sel ? b_val  : a_val;
        ocnt  = sel ? b_cnt  : a_cnt;
    end

    // index of the extreme entry in the model, -1 when empty
    function automatic int best_idx();
        int b = -1;
        foreach (mk[j]) begin
            if (b < 0) b = j;
            else if (!sel && mk[j] > mk[b]) b = j;
            else if (sel && mk[j] < mk[b]) b = j;
        end
        return b;
    endfunction

    function automatic bit model_apply(bit w, bit r, int k, int v);
        int b = best_idx();
        if (w && r) begin
            if (b >= 0) begin
                mk.delete(b);
                mv.delete(b);
            end
            mk.push_back(k);
            mv.push_back(v);
            return 1'b1;
        end
        if (w) begin
            if (mk.size() >= QS) return 1'b0;
            mk.push_back(k);
            mv.push_back(v);
            return 1'b1;
        end
        if (b < 0) return 1'b0;
        mk.delete(b);
        mv.delete(b);
        return 1'b1;
    endfunction

    function automatic int fresh_key();
        int  k;
        bit  dup;
        do begin
            if ($urandom_range(0, 3) == 0)
                k = ($urandom_range(0, 1) == 0) ? 0 : 255;
            else
                k = $urandom_range(0, 255);
            dup = 1'b0;
            foreach (mk[j]) if (mk[j] == k) dup = 1'b1;
        end while (dup);
        return k;
    endfunction

    task automatic do_reset();
        wrt   = 1'b0;
        rd    = 1'b0;
        rst_n = 1'b0;
        mk.delete();
        mv.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue(input bit w, input bit r, input int k, input int v);
        int n = 0;
        while (rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL issue_wait ready=%b required 1", rdy);
        end
        wrt = w;
        rd  = r;
        key = KW'(k);
        val = VW'(v);
        @(posedge clk);
        #1;
        wrt = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (rdy !== 1'b1 || ovld !== 1'b0 || oemp !== 1'b1 ||
                ofull !== 1'b0 || okey !== '0 || oval !== '0 ||
                ocnt !== '0 || odrop !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle rdy=%b vld=%b emp=%b full=%b key=%0d val=%0d cnt=%0d drop=%b required 1 0 1 0 0 0 0 0",
                         rdy, ovld, oemp, ofull, okey, oval, ocnt, odrop);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enqueue();
        int ks[4] = '{5, 9, 0, 7};
        int er[4] = '{5, 9, 9, 9};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, ks[i], i + 1);
            for (int c = 0; c < TD; c++) begin
                @(negedge clk);
                tests++;
                if (rdy !== 1'b0 || ovld !== 1'b0) begin
                    fails++;
                    $display("FAIL enq_busy rdy=%b vld=%b required 0 0",
                             rdy, ovld);
                end
            end
            @(negedge clk);
            tests++;
            if (rdy !== 1'b1 || ovld !== 1'b1 || okey !== KW'(er[i]) ||
                ocnt !== CW'(i + 1)) begin
                fails++;
                $display("FAIL enq_root rdy=%b vld=%b key=%0d cnt=%0d required 1 1 %0d %0d",
                         rdy, ovld, okey, ocnt, er[i], i + 1);
            end
        end
        tests++;
        if (oval !== VW'(2)) begin
            fails++;
            $display("FAIL enq_value value=%0d required 2", oval);
        end
    endtask

    task automatic test_dequeue();
        int er[4] = '{7, 5, 0, 0};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, 0, 0);
            repeat (TD + 1) @(negedge clk);
            tests++;
            if (rdy !== 1'b1 || okey !== KW'(er[i]) ||
                ocnt !== CW'(3 - i) || ovld !== (i < 3)) begin
                fails++;
                $display("FAIL deq_root rdy=%b vld=%b key=%0d cnt=%0d required 1 %0d %0d %0d",
                         rdy, ovld, okey, ocnt, i < 3, er[i], 3 - i);
            end
        end
        tests++;
        if (oemp !== 1'b1) begin
            fails++;
            $display("FAIL deq_empty empty=%b required 1", oemp);
        end
        issue(1'b0, 1'b1, 0, 0);
        @(negedge clk);
        tests++;
        if (odrop !== 1'b1 || rdy !== 1'b1 || ocnt !== '0) begin
            fails++;
            $display("FAIL deq_drop drop=%b rdy=%b cnt=%0d required 1 1 0",
                     odrop, rdy, ocnt);
        end
        @(negedge clk);
        tests++;
        if (odrop !== 1'b0 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL deq_drop_end drop=%b rdy=%b required 0 1",
                     odrop, rdy);
        end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 7; k++) issue(1'b1, 1'b0, k, k);
        repeat (TD + 1) @(negedge clk);
        tests++;
        if (ofull !== 1'b1 || ocnt !== CW'(7) || okey !== KW'(7)) begin
            fails++;
            $display("FAIL full_state full=%b cnt=%0d key=%0d required 1 7 7",
                     ofull, ocnt, okey);
        end
        issue(1'b1, 1'b0, 200, 9);
        @(negedge clk);
        tests++;
        if (odrop !== 1'b1 || rdy !== 1'b1 || ocnt !== CW'(7) ||
            okey !== KW'(7) || oval !== VW'(7)) begin
            fails++;
            $display("FAIL full_drop drop=%b rdy=%b cnt=%0d key=%0d val=%0d required 1 1 7 7 7",
                     odrop, rdy, ocnt, okey, oval);
        end
        issue(1'b1, 1'b1, 3, 3);
        repeat (TD + 1) @(negedge clk);
        tests++;
        if (rdy !== 1'b1 || okey !== KW'(6) || oval !== VW'(6) ||
            ocnt !== CW'(7)) begin
            fails++;
            $display("FAIL full_replace rdy=%b key=%0d val=%0d cnt=%0d required 1 6 6 7",
                     rdy, okey, oval, ocnt);
        end
    endtask

    task automatic test_min_mode();
        int er[3] = '{5, 9, 0};
        sel = 1'b1;
        do_reset();
        issue(1'b1, 1'b0, 5, 1);
        issue(1'b1, 1'b0, 9, 2);
        issue(1'b1, 1'b0, 3, 3);
        repeat (TD + 1) @(negedge clk);
        tests++;
        if (okey !== KW'(3) || oval !== VW'(3) || ocnt !== CW'(3)) begin
            fails++;
            $display("FAIL min_root key=%0d val=%0d cnt=%0d required 3 3 3",
                     okey, oval, ocnt);
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b1, 0, 0);
            repeat (TD + 1) @(negedge clk);
            tests++;
            if (okey !== KW'(er[i]) || ocnt !== CW'(2 - i)) begin
                fails++;
                $display("FAIL min_deq key=%0d cnt=%0d required %0d %0d",
                         okey, ocnt, er[i], 2 - i);
            end
        end
        issue(1'b1, 1'b1, 4, 5);
        repeat (TD + 1) @(negedge clk);
        tests++;
        if (okey !== KW'(4) || oval !== VW'(5) || ocnt !== CW'(1) ||
            ovld !== 1'b1) begin
            fails++;
            $display("FAIL min_rep_empty key=%0d val=%0d cnt=%0d vld=%b required 4 5 1 1",
                     okey, oval, ocnt, ovld);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        do_reset();
        issue(1'b1, 1'b0, 33, 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rdy !== 1'b1 || ovld !== 1'b0 || oemp !== 1'b1 ||
            ofull !== 1'b0 || okey !== '0 || oval !== '0 ||
            ocnt !== '0 || odrop !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid rdy=%b vld=%b emp=%b full=%b key=%0d val=%0d cnt=%0d drop=%b required 1 0 1 0 0 0 0 0",
                     rdy, ovld, oemp, ofull, okey, oval, ocnt, odrop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 8, 2);
        repeat (TD + 1) @(negedge clk);
        tests++;
        if (okey !== KW'(8) || ocnt !== CW'(1) || ovld !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_after key=%0d cnt=%0d vld=%b required 8 1 1",
                     okey, ocnt, ovld);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_reset();
        wrt = 1'b1;
        for (int c = 0; c < 4 * (TD + 1); c++) begin
            key = KW'(c);
            @(negedge clk);
            tests++;
            if (ocnt !== CW'(c / (TD + 1) + 1) || odrop !== 1'b0) begin
                fails++;
                $display("FAIL b2b_count cycle=%0d cnt=%0d drop=%b required %0d 0",
                         c, ocnt, odrop, c / (TD + 1) + 1);
            end
        end
        wrt = 1'b0;
        @(negedge clk);
        tests++;
        if (rdy !== 1'b1 || okey !== KW'(12) || ocnt !== CW'(4)) begin
            fails++;
            $display("FAIL b2b_root rdy=%b key=%0d cnt=%0d required 1 12 4",
                     rdy, okey, ocnt);
        end
    endtask

    task automatic test_random(input bit mode);
        int op, k, v, b, ek, ev;
        bit w, r, legal;
        sel = mode;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op    = $urandom_range(0, 3);
            w     = (op != 2);
            r     = (op >= 2);
            k     = fresh_key();
            v     = $urandom_range(0, 15);
            legal = model_apply(w, r, k, v);
            issue(w, r, k, v);
            @(negedge clk);
            if (legal) begin
                tests++;
                if (ocnt !== CW'(mk.size()) || rdy !== 1'b0 ||
                    odrop !== 1'b0) begin
                    fails++;
                    $display("FAIL rnd_accept mode=%0d cnt=%0d rdy=%b drop=%b required %0d 0 0",
                             mode, ocnt, rdy, odrop, mk.size());
                end
                repeat (TD) @(negedge clk);
                b  = best_idx();
                ek = (b < 0) ? 0 : mk[b];
                ev = (b < 0) ? 0 : mv[b];
                tests++;
                if (rdy !== 1'b1 || ovld !== (b >= 0) ||
                    okey !== KW'(ek) || oval !== VW'(ev) ||
                    oemp !== (mk.size() == 0) ||
                    ofull !== (mk.size() == QS)) begin
                    fails++;
                    $display("FAIL rnd_root mode=%0d rdy=%b vld=%b key=%0d val=%0d emp=%b full=%b required 1 %0d %0d %0d %0d %0d",
                             mode, rdy, ovld, okey, oval, oemp, ofull,
                             b >= 0, ek, ev, mk.size() == 0,
                             mk.size() == QS);
                end
            end else begin
                tests++;
                if (odrop !== 1'b1 || rdy !== 1'b1 ||
                    ocnt !== CW'(mk.size())) begin
                    fails++;
                    $display("FAIL rnd_drop mode=%0d drop=%b rdy=%b cnt=%0d required 1 1 %0d",
                             mode, odrop, rdy, ocnt, mk.size());
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_enqueue();
        test_dequeue();
        test_full();
        test_min_mode();
        test_reset_mid();
        test_back_to_back();
        test_random(1'b0);
        test_random(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
